// File: rtl/pkt_sink_chk_if.sv
// Packet stream interface between the FIFO read side and the sink/checker.
//
// Handshake: a word transfers on a rising clk edge where din_vld && b_rdy.
// The source holds din/din_sop/din_eop stable while din_vld is high and
// b_rdy is low. b_rdy does not depend on din_vld.
//
// Signals:
//   din      stream data word
//   din_vld  data valid (source to sink)
//   din_sop  first word of packet
//   din_eop  last word of packet
//   b_rdy    sink ready (sink to source)
// Modports: master = stream source, slave = stream sink.
interface pkt_sink_chk_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] din;
  logic              din_vld;
  logic              din_sop;
  logic              din_eop;
  logic              b_rdy;

  modport master (
    output din, din_vld, din_sop, din_eop,
    input  b_rdy
  );

  modport slave (
    input  din, din_vld, din_sop, din_eop,
    output b_rdy
  );
endinterface

// File: rtl/pkt_sink_chk.sv
// Packet stream sink and checker.
//
// Consumes a sop/eop framed stream and checks framing, an incrementing-byte
// payload pattern and the packet length. Each packet end produces one
// registered status record plus saturating packet and error counters.
//
// Optional feature: define PKT_SINK_RDY_THROTTLE_EN to throttle b_rdy with a
// free-running pattern (RDY_ON high cycles out of every RDY_PERIOD). Without
// it, b_rdy is 1 from the first clock edge after reset.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   s_if         stream sink (din, din_vld, din_sop, din_eop in; b_rdy out)
//   pkt_done     one-cycle pulse, status record updated
//   pkt_len      accepted word count of the reported packet (<= MAX_LEN)
//   pkt_ok       1 when err_code == 0
//   err_code     bit0 framing, bit1 data pattern, bit2 overlength
//   pkt_cnt      reports issued, saturating
//   err_cnt      reports with pkt_ok = 0, saturating
//   state_dbg    current FSM state (0 IDLE, 1 BODY, 2 DROP)
module pkt_sink_chk #(
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 16,
  parameter int MAX_LEN    = 1024,
  parameter int RDY_ON     = 3,
  parameter int RDY_PERIOD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  pkt_sink_chk_if.slave    s_if,
  output logic             pkt_done,
  output logic [LEN_W-1:0] pkt_len,
  output logic             pkt_ok,
  output logic [2:0]       err_code,
  output logic [LEN_W-1:0] pkt_cnt,
  output logic [LEN_W-1:0] err_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BODY = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [2:0]        err_q, err_d;
  logic              b_rdy_q, b_rdy_d;
  logic              pkt_done_q, pkt_done_d;
  logic [LEN_W-1:0]  pkt_len_q, pkt_len_d;
  logic              pkt_ok_q, pkt_ok_d;
  logic [2:0]        err_code_q, err_code_d;
  logic [LEN_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [LEN_W-1:0]  err_cnt_q, err_cnt_d;

  logic              accept;
  logic              report;
  logic [DATA_W-1:0] din_inc;
  logic [LEN_W-1:0]  len_inc;

  assign accept  = s_if.din_vld && b_rdy_q;
  assign din_inc = s_if.din + DATA_W'(1);
  assign len_inc = (len_q == MAX_L) ? MAX_L : len_q + LEN_W'(1);

`ifdef PKT_SINK_RDY_THROTTLE_EN
  // Wide enough to hold RDY_PERIOD itself, so RDY_ON == RDY_PERIOD fits.
  localparam int THR_W = $clog2(RDY_PERIOD + 1);
  localparam logic [THR_W-1:0] THR_ON   = THR_W'(RDY_ON);
  localparam logic [THR_W-1:0] THR_LAST = THR_W'(RDY_PERIOD - 1);

  logic [THR_W-1:0] thr_q, thr_d;

  always_comb begin
    thr_d   = (thr_q == THR_LAST) ? '0 : thr_q + THR_W'(1);
    b_rdy_d = (thr_q < THR_ON);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) thr_q <= '0;
    else        thr_q <= thr_d;
  end
`else
  always_comb b_rdy_d = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    exp_d   = exp_q;
    err_d   = err_q;
    report  = 1'b0;
    if (accept) begin
      if (state_q == IDLE || s_if.din_sop) begin
        // Any sop restarts a packet; a fragment in progress is discarded
        // without a report. A word that is not a clean IDLE sop is framing.
        len_d   = LEN_W'(1);
        exp_d   = din_inc;
        err_d   = (state_q == IDLE && s_if.din_sop) ? 3'b000 : 3'b001;
        state_d = s_if.din_sop ? BODY : DROP;
      end else begin
        len_d = len_inc;
        exp_d = din_inc;
        if (state_q == BODY && s_if.din != exp_q) err_d[1] = 1'b1;
        if (len_q == MAX_L)                     err_d[2] = 1'b1;
      end
      if (s_if.din_eop) begin
        report  = 1'b1;
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    pkt_done_d = report;
    pkt_len_d  = report ? len_d : pkt_len_q;
    err_code_d = report ? err_d : err_code_q;
    pkt_ok_d   = report ? (err_d == 3'b000) : pkt_ok_q;
    pkt_cnt_d  = pkt_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (report && pkt_cnt_q != '1) pkt_cnt_d = pkt_cnt_q + LEN_W'(1);
    if (report && err_d != 3'b000 && err_cnt_q != '1) err_cnt_d = err_cnt_q + LEN_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      exp_q      <= '0;
      err_q      <= '0;
      b_rdy_q    <= 1'b0;
      pkt_done_q <= 1'b0;
      pkt_len_q  <= '0;
      pkt_ok_q   <= 1'b0;
      err_code_q <= '0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      exp_q      <= exp_d;
      err_q      <= err_d;
      b_rdy_q    <= b_rdy_d;
      pkt_done_q <= pkt_done_d;
      pkt_len_q  <= pkt_len_d;
      pkt_ok_q   <= pkt_ok_d;
      err_code_q <= err_code_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign s_if.b_rdy = b_rdy_q;
  assign pkt_done   = pkt_done_q;
  assign pkt_len    = pkt_len_q;
  assign pkt_ok     = pkt_ok_q;
  assign err_code   = err_code_q;
  assign pkt_cnt    = pkt_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign state_dbg  = state_q;

endmodule

// File: doc/pkt_sink_chk.md
# pkt_sink_chk

Packet stream sink and checker on the downstream side of `fifo_p`. It consumes the `dout`/`dout_vld`/`dout_sop`/`dout_eop` packet stream and drives `b_rdy` back to the FIFO, with optional ready throttling. It checks framing, the incrementing-byte payload pattern and packet length, then reports one status record per packet plus saturating packet and error counters.

## Interface
- `DATA_W`, 8: data width.
- `LEN_W`, 16: width of length and counters.
- `MAX_LEN`, 1024: maximum legal packet length in words (≥2, < 2^LEN_W).
- `RDY_ON`, 3: `b_rdy`-high cycles per throttle period (used only with the macro).
- `RDY_PERIOD`, 4: throttle period in cycles, ≥ `RDY_ON`, ≥1.
---
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `din`  in  DATA_W  stream data (connects to FIFO `dout`).
- `din_vld`  in  1  data valid.
- `din_sop`  in  1  first word of packet.
- `din_eop`  in  1  last word of packet.
- `b_rdy`  out  1  sink ready; word accepted when `din_vld && b_rdy`.
- `pkt_done`  out  1  one-cycle pulse: status record updated.
- `pkt_len`  out  LEN_W  accepted word count of reported packet.
- `pkt_ok`  out  1  1 = packet clean (`err_code==0`).
- `err_code`  out  3  bit0 framing, bit1 data pattern, bit2 overlength.
- `pkt_cnt`  out  LEN_W  reports issued, saturating.
- `err_cnt`  out  LEN_W  reports with `pkt_ok=0`, saturating.

## Operation
- Inputs are sampled only on accept (`din_vld && b_rdy`). Non-accepted cycles change nothing except the throttle counter.
- FSM states: IDLE, BODY, DROP. Reset → IDLE.
- IDLE accept with sop: start a packet with len=1 and expected=`din`+1, err=000.
  - eop also set → report immediately; stay IDLE.
  - otherwise → BODY.
- IDLE accept without sop: stray word; len=1, err bit0 set.
  - eop set → report; stay IDLE.
  - otherwise → DROP.
- BODY accept without sop:
  - len increments, saturating at `MAX_LEN`.
  - If `din` ≠ expected, set bit1.
  - expected = `din`+1 (mod 2^DATA_W) regardless of mismatch.
  - If len already equals `MAX_LEN`, set bit2.
  - eop → report, go to IDLE.
- BODY accept with sop: the current packet is silently discarded. A new packet starts from this word with bit0 preset; it is BODY, or reported immediately if eop is also set.
- DROP accept: counts len as in BODY, with no pattern check.
  - eop → report (bit0), go to IDLE.
  - sop → discard the fragment; start a new packet with bit0 preset, as in the BODY-with-sop case.
- Report contents: `pkt_len`, `err_code`, `pkt_ok` are registered and held until the next report.
  - `pkt_cnt` increments once per report.
  - `err_cnt` increments when `pkt_ok=0`.
  - Both counters saturate at all-ones.
- At most one report per cycle by construction.

## Timing
- Reset values: `b_rdy`=0, `pkt_done`=0, `pkt_len`=0, `pkt_ok`=0, `err_code`=000, `pkt_cnt`=0, `err_cnt`=0.
- Report latency: `pkt_done` and the record are valid in the cycle after the eop accept edge, i.e. registered, 1 cycle.
- `b_rdy` is registered. A change of `b_rdy` takes effect on the next accept decision, and the FIFO sees it in the same cycle.
- Back-to-back packets with sop on the cycle after eop are accepted with no bubble.
- Reset asserted mid-packet: everything returns to reset values, and the partial packet is lost without a report.
- Length saturation: `pkt_len` never exceeds `MAX_LEN`.

## Configuration
- `PKT_SINK_RDY_THROTTLE_EN` defined:
  - A free-running counter runs 0..`RDY_PERIOD`-1 from reset.
  - `b_rdy` = (counter < `RDY_ON`), registered, so the pattern starts one cycle after reset deassertion.
- Macro undefined:
  - `b_rdy` = 1 from the first clock edge after reset deassertion, constant thereafter.
  - `RDY_ON` and `RDY_PERIOD` are ignored.

## Test plan
- **Clean packet**: no throttle; 150-word packet, data 0..149, sop on word 0, eop on word 149 → one `pkt_done` one cycle after eop; `pkt_len`=150, `err_code`=000, `pkt_ok`=1, `pkt_cnt`=1, `err_cnt`=0.
- **Data corruption**: same packet with word 5 = 0xFF → `pkt_len`=150, `err_code`=010, `pkt_ok`=0, `err_cnt`=1.
- **Framing errors**:
  - 3 words without sop, eop on word 3 → `pkt_len`=3, `err_code`=001.
  - sop inside a 10-word packet at word 4, then clean to eop → a single report, `pkt_len`=7, `err_code`=001.
- **Overlength**: `MAX_LEN`=16, 20-word clean packet → `pkt_len`=16, `err_code`=100.
- **Throttle**: macro on, `RDY_ON`=3, `RDY_PERIOD`=4, `din_vld` held high for a 150-word packet → `b_rdy` repeats 1,1,1,0; exactly 150 accepts over 200 cycles; `pkt_len`=150, `err_code`=000.
- **Reset mid-packet**: reset asserted at word 50 of 150 → all outputs at reset values, no `pkt_done`. A following clean 20-word packet reports `pkt_len`=20, `pkt_cnt`=1.
